// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle adder/subtractor built from one 8-bit ripple-carry slice.
// Operands are processed one byte lane per clock, LSB lane first; the inter-lane carry
// lives in a register. Command side and result side use valid/ready handshakes.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OVF_EN.

module rca_seq_adder #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  input  logic                   cin,
  input  logic                   op_sub,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*NUM_BYTES-1:0] sum,
  output logic                   cout
`ifdef RCA_SEQ_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int unsigned W    = 8 * NUM_BYTES;
  localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;

  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic            r_carry;
  logic [IdxW-1:0] r_idx;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic            w_accept;
  logic            w_last;
  logic [7:0]      w_lane_a;
  logic [7:0]      w_lane_b;
  logic [8:0]      w_lane_sum;
  logic [W-1:0]    w_sum_nxt;

`ifdef RCA_SEQ_OVF_EN
  logic            r_ovf;
  logic [7:0]      w_lane_lo7;
  logic            w_lane_ovf;
`endif

  assign w_last = (r_idx == LastIdx);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and accept strobe
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Current lane slice add and merge of the new byte into the partial sum
  always_comb begin
    w_lane_a   = 8'(r_op_a >> {r_idx, 3'b000});
    w_lane_b   = 8'(r_op_b >> {r_idx, 3'b000});
    w_lane_sum = {1'b0, w_lane_a} + {1'b0, w_lane_b} + {8'b0, r_carry};
    // Uncomputed bytes are still zero, so OR-ing the lane in is a byte write.
    w_sum_nxt  = r_sum | (W'(w_lane_sum[7:0]) << {r_idx, 3'b000});
  end

`ifdef RCA_SEQ_OVF_EN
  // Carry into the top bit of the lane; XOR with carry-out gives signed overflow
  always_comb begin
    w_lane_lo7 = {1'b0, w_lane_a[6:0]} + {1'b0, w_lane_b[6:0]} + {7'b0, r_carry};
    w_lane_ovf = w_lane_lo7[7] ^ w_lane_sum[8];
  end
`endif

  // Operand capture on accept, then one lane per clock while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= a;
      // Subtract is A + ~B + 1
      r_op_b  <= op_sub ? ~b : b;
      r_carry <= op_sub ? 1'b1 : cin;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == StRun) begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_lane_sum[8];
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_lane_sum[8];
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

`ifdef RCA_SEQ_OVF_EN
  // Overflow flag registered alongside cout on the final lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == StRun) && w_last) begin
      r_ovf <= w_lane_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  // Ready is suppressed while reset is held even though the state reads idle
  assign start_ready = rst_n && (r_state == StIdle);
  assign res_valid   = (r_state == StDone);
  assign sum         = r_sum;
  assign cout        = r_cout;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Self-checking bench for rca_seq_adder (NUM_BYTES=4): directed corner cases plus
// randomized operations compared against a plain-arithmetic reference model.

module tb_rca_seq_adder;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef RCA_SEQ_OVF_EN
  logic         ovf;
`endif

  int total;
  int bad;

  rca_seq_adder #(
    .NUM_BYTES(NB)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .op_sub     (op_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .sum        (sum),
    .cout       (cout)
`ifdef RCA_SEQ_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width arithmetic, carry/borrow and exact signed range test
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mcin, input logic msub,
                                output logic [W-1:0] s, output logic c, output logic v);
    logic [W:0] t;
    longint     sa;
    longint     sb;
    longint     sr;
    sa = $signed({{32{ma[W-1]}}, ma});
    sb = $signed({{32{mb[W-1]}}, mb});
    if (msub) begin
      t  = {1'b0, ma} - {1'b0, mb};
      c  = (ma >= mb);
      sr = sa - sb;
    end else begin
      t  = {1'b0, ma} + {1'b0, mb} + {32'b0, mcin};
      c  = t[W];
      sr = sa + sb + longint'(mcin);
    end
    s = t[W-1:0];
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  // One full transaction: handshake, latency, partial sums, hold in DONE, release
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input logic tsub, input int hold);
    logic [W-1:0] es;
    logic         ec;
    logic         ev;
    logic [63:0]  mask;
    bit           got_ready;
    model(ta, tb_v, tcin, tsub, es, ec, ev);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; op_sub = tsub; start_valid = 1'b1; res_ready = 1'b0;
    got_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (start_ready) begin
        got_ready = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_ready) begin
      check("ready_timeout", 64'(start_ready), 64'd1);
      start_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Inputs after accept must have no effect
    start_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); op_sub = 1'($urandom);
    check("sum_cleared", 64'(sum), 64'd0);
    check("valid_early", 64'(res_valid), 64'd0);
    for (int k = 1; k <= int'(NB); k++) begin
      start_valid = 1'($urandom);
      res_ready   = 1'($urandom);
      @(posedge clk);
      #1;
      mask = (64'd1 << (8 * k)) - 64'd1;
      check("partial_sum", 64'(sum), 64'(es) & mask);
      check("latency", 64'(res_valid), 64'(k == int'(NB)));
      check("ready_busy", 64'(start_ready), 64'd0);
    end
    check("cout", 64'(cout), 64'(ec));
`ifdef RCA_SEQ_OVF_EN
    check("ovf", 64'(ovf), 64'(ev));
`endif
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0; start_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_sum", 64'(sum), 64'(es));
      check("hold_cout", 64'(cout), 64'(ec));
      check("hold_ready", 64'(start_ready), 64'd0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("release_valid", 64'(res_valid), 64'd0);
    check("release_ready", 64'(start_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    res_ready = 1'b0;
    #12;
    check("rst_ready", 64'(start_ready), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 64'(start_ready), 64'd1);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 0);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 5);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 2);

    // Abort mid-run after lanes 0 and 1
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h0101_0101; cin = 1'b0; op_sub = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 64'(start_ready), 64'd0);
    check("abort_valid", 64'(res_valid), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_valid", 64'(res_valid), 64'd0);
    end
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
